iob_wishbone2iob: RTL and testbench
===================================

Name: iob_wishbone2iob

Overview:
- Bridge from a Wishbone classic slave port to an IOb master port.
- Lets the ethmac DMA Wishbone master (buffer descriptors, frame data) reach system memory on the IOb bus.
- Opposite-direction partner of the IOb-to-Wishbone register bridge in the same MAC subsystem.
- One outstanding transaction. All IOb outputs and Wishbone responses are registered.

Parameters:
- ADDR_W, 32: address width, byte address, passed through unchanged.
- DATA_W, 32: data width. Strobe and select width is DATA_W/8.
- TIMEOUT_W, 16: width of the watchdog counter. Used only when the optional feature is enabled.

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  reset, synchronous, active-high.
- wb_addr_i  in  ADDR_W  Wishbone address.
- wb_data_i  in  DATA_W  Wishbone write data.
- wb_select_i  in  DATA_W/8  Wishbone byte select.
- wb_we_i  in  1  Wishbone write enable.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_data_o  out  DATA_W  Wishbone read data.
- wb_ack_o  out  1  Wishbone acknowledge.
- wb_error_o  out  1  Wishbone error.
- valid_o  out  1  IOb request valid.
- address_o  out  ADDR_W  IOb address.
- wdata_o  out  DATA_W  IOb write data.
- wstrb_o  out  DATA_W/8  IOb write strobe; zero means read.
- rdata_i  in  DATA_W  IOb read data.
- ready_i  in  1  IOb response ready.
- timeout_cfg_i  in  TIMEOUT_W  watchdog limit in cycles. Present only with the optional feature.

Behaviour:
- Clocking: single clock domain, clk_i. Reset is synchronous, active-high, and is the arst_i port.
- Reset value of every output is 0. State returns to IDLE.
- Reset mid-transaction aborts silently: valid_o drops next edge and no ack is issued.
- FSM states: IDLE, REQ, ACK.
- IDLE:
  - Samples wb_cyc_i & wb_stb_i.
  - On a hit, registers wb_addr_i, wb_data_i, wb_we_i and wb_select_i.
  - wstrb_o is loaded with wb_select_i when wb_we_i=1, else 0.
  - Normal case: sets valid_o=1 and goes to REQ.
  - Special case, write with wb_select_i==0: no IOb access. Goes to ACK with wb_ack_o=1.
- REQ:
  - valid_o, address_o, wdata_o and wstrb_o are held stable until ready_i is sampled high.
  - ready_i may be high in the first cycle valid_o is high.
  - On ready_i: valid_o=0, wb_data_o<=rdata_i (reads only; wb_data_o holds its value on writes), wb_ack_o=1, go to ACK.
- ACK:
  - wb_ack_o is high for exactly one cycle, then state returns to IDLE.
  - IDLE may accept the next request on the following edge. This supports a master that keeps stb asserted with a new address.
- Latency:
  - Request sampled at edge N, valid_o high from N+1.
  - With ready_i at N+1, wb_ack_o is high at N+2.
  - Minimum issue interval is 3 cycles.
- Master abort: if wb_cyc_i drops while in REQ, the IOb access still completes (IOb cannot abort). wb_ack_o is suppressed for that transaction. wb_data_o is still updated.
- ready_i sampled outside REQ is ignored.
- Without the optional feature, wb_error_o is constant 0.
- Wishbone pass-through: address and data are not modified. No byte lane shifting.

Optional Feature:
- Macro: IOB_WISHBONE2IOB_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to REQ and increments each cycle in REQ without ready_i.
  - When the count equals timeout_cfg_i: valid_o=0, wb_error_o=1 for one cycle (no ack), state goes to ACK and then IDLE.
  - A late ready_i arriving after the timeout is ignored.
  - timeout_cfg_i=0 disables the watchdog.
- Undefined: no counter, no timeout_cfg_i port, wb_error_o tied 0.

Test Plan:
- Read: cyc=stb=1, we=0, addr=0x100; ready_i=1 with rdata_i=0xDEADBEEF two cycles after valid_o -> address_o=0x100, wstrb_o=0x0, wb_data_o=0xDEADBEEF, one-cycle wb_ack_o.
- Write: we=1, sel=0x6, addr=0x204, data=0x11223344 -> wstrb_o=0x6, wdata_o=0x11223344, outputs stable until ready_i, then one ack. Zero-wait ready_i case gives ack at N+2.
- Back-to-back: 4 reads at 0x0, 0x4, 0x8, 0xC with stb held and ready_i same-cycle -> 4 acks at 3-cycle spacing, correct address order.
- Zero-select write: we=1, sel=0 -> valid_o never rises, single wb_ack_o.
- Master abort and reset: cyc dropped during REQ -> IOb completes, no ack. Separate run: arst_i=1 while in REQ -> all outputs 0 next edge, next request works normally.
- Timeout (macro defined): timeout_cfg_i=8, ready_i never asserted -> wb_error_o pulse 8 cycles after valid_o rises, no ack. A later stray ready_i is ignored.

Source files
------------

// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave to IOb master bridge with one outstanding access and registered outputs.
// Optional watchdog: define IOB_WISHBONE2IOB_TIMEOUT_EN to add timeout_cfg_i and drive wb_error_o.

module iob_wishbone2iob #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [ADDR_W-1:0]      wb_addr_i,
  input  logic [DATA_W-1:0]      wb_data_i,
  input  logic [DATA_W/8-1:0]    wb_select_i,
  input  logic                   wb_we_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  output logic [DATA_W-1:0]      wb_data_o,
  output logic                   wb_ack_o,
  output logic                   wb_error_o,
  output logic                   valid_o,
  output logic [ADDR_W-1:0]      address_o,
  output logic [DATA_W-1:0]      wdata_o,
  output logic [DATA_W/8-1:0]    wstrb_o,
  input  logic [DATA_W-1:0]      rdata_i,
  input  logic                   ready_i
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
  ,
  input  logic [TIMEOUT_W-1:0]   timeout_cfg_i
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t              state_q;
  logic                valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                we_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ack_q;
  logic                abort_q;

`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;
  logic                 error_q;

  assign cnt_d      = cnt_q + TIMEOUT_W'(1);
  assign wb_error_o = error_q;
`else
  assign wb_error_o = 1'b0;
`endif

  assign valid_o   = valid_q;
  assign address_o = addr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wb_data_o = rdata_q;
  assign wb_ack_o  = ack_q;

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      abort_q <= 1'b0;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
      cnt_q   <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            addr_q  <= wb_addr_i;
            wdata_q <= wb_data_i;
            we_q    <= wb_we_i;
            wstrb_q <= wb_we_i ? wb_select_i : '0;
            abort_q <= 1'b0;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            // A write that enables no byte lanes has nothing to do on IOb.
            if (wb_we_i && (wb_select_i == '0)) begin
              ack_q   <= 1'b1;
              state_q <= ACK;
            end else begin
              valid_q <= 1'b1;
              state_q <= REQ;
            end
          end
        end

        REQ: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            if (!we_q) rdata_q <= rdata_i;
            ack_q   <= wb_cyc_i && !abort_q;
            state_q <= ACK;
          end
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
          else if ((timeout_cfg_i != '0) && (cnt_d == timeout_cfg_i)) begin
            valid_q <= 1'b0;
            error_q <= wb_cyc_i && !abort_q;
            state_q <= ACK;
          end
`endif
          else begin
            // IOb cannot abort, so a dropped cycle only silences the response.
            if (!wb_cyc_i) abort_q <= 1'b1;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
            cnt_q <= cnt_d;
`endif
          end
        end

        ACK: begin
          ack_q   <= 1'b0;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
          error_q <= 1'b0;
`endif
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Randomized self-checking bench for iob_wishbone2iob against a memory-level reference model.
// Exercises the watchdog only when IOB_WISHBONE2IOB_TIMEOUT_EN is defined.

module tb_iob_wishbone2iob;

  logic        clk = 1'b0;
  logic        arst;
  logic [31:0] wbAddr, wbData, wbDataO;
  logic [3:0]  wbSel;
  logic        wbWe, wbCyc, wbStb, wbAck, wbErr;
  logic        valid, ready;
  logic [31:0] address, wdata, rdata;
  logic [3:0]  wstrb;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
  logic [15:0] timeoutCfg;
`endif

  int assertCount = 0;
  int failCount   = 0;

  // refMem is what Wishbone-side writes imply; slvMem is what the IOb side actually received.
  logic [31:0] refMem [16];
  logic [31:0] slvMem [16];
  logic [31:0] expWbData;

  iob_wishbone2iob #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(16)) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .wb_addr_i   (wbAddr),
    .wb_data_i   (wbData),
    .wb_select_i (wbSel),
    .wb_we_i     (wbWe),
    .wb_cyc_i    (wbCyc),
    .wb_stb_i    (wbStb),
    .wb_data_o   (wbDataO),
    .wb_ack_o    (wbAck),
    .wb_error_o  (wbErr),
    .valid_o     (valid),
    .address_o   (address),
    .wdata_o     (wdata),
    .wstrb_o     (wstrb),
    .rdata_i     (rdata),
    .ready_i     (ready)
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
    ,
    .timeout_cfg_i (timeoutCfg)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One Wishbone access; ready comes waitCyc cycles after valid rises. Called and returns at a negedge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                               input logic we, input int waitCyc, input bit holdNext);
    logic [3:0] idx;
    logic [3:0] expStrb;
    idx     = addr[5:2];
    expStrb = we ? sel : 4'h0;
    wbAddr = addr; wbData = data; wbSel = sel; wbWe = we; wbCyc = 1'b1; wbStb = 1'b1;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) refMem[idx][8*b +: 8] = data[8*b +: 8];
    end else begin
      expWbData = refMem[idx];
    end
    cycle();
    if (!(we && sel == 4'h0)) begin
      for (int k = 0; k <= waitCyc; k++) begin
        checkOutput("req valid", {31'd0, valid}, 32'd1);
        checkOutput("req address", address, addr);
        checkOutput("req wstrb", {28'd0, wstrb}, {28'd0, expStrb});
        checkOutput("req wdata", wdata, data);
        checkOutput("req ack low", {31'd0, wbAck}, 32'd0);
        if (k == waitCyc) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) slvMem[address[5:2]][8*b +: 8] = wdata[8*b +: 8];
          rdata = slvMem[address[5:2]];
          ready = 1'b1;
        end
        cycle();
      end
      ready = 1'b0;
      rdata = $urandom;
    end
    checkOutput("ack high", {31'd0, wbAck}, 32'd1);
    checkOutput("ack valid low", {31'd0, valid}, 32'd0);
    checkOutput("ack err low", {31'd0, wbErr}, 32'd0);
    checkOutput("wb rdata", wbDataO, expWbData);
    if (!holdNext) begin
      wbCyc = 1'b0;
      wbStb = 1'b0;
    end
    cycle();
    checkOutput("ack one cycle", {31'd0, wbAck}, 32'd0);
    checkOutput("post ack valid", {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int validCycles;
    logic [31:0] rAddr;
    arst = 1'b1;
    wbAddr = '0; wbData = '0; wbSel = '0; wbWe = 1'b0; wbCyc = 1'b0; wbStb = 1'b0;
    ready = 1'b0; rdata = '0;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
    timeoutCfg = '0;
`endif
    for (int i = 0; i < 16; i++) begin
      refMem[i] = $urandom;
      slvMem[i] = refMem[i];
    end
    refMem[0] = 32'hDEADBEEF;
    slvMem[0] = 32'hDEADBEEF;
    expWbData = '0;

    repeat (3) cycle();
    checkOutput("reset valid", {31'd0, valid}, 32'd0);
    checkOutput("reset ack", {31'd0, wbAck}, 32'd0);
    checkOutput("reset err", {31'd0, wbErr}, 32'd0);
    checkOutput("reset wbdata", wbDataO, 32'd0);
    checkOutput("reset address", address, 32'd0);
    checkOutput("reset wstrb", {28'd0, wstrb}, 32'd0);
    arst = 1'b0;

    $display("[TB] directed read, writes and readback");
    applyStimulus(32'h0000_0100, 32'hCAFE_0000, 4'hF, 1'b0, 2, 1'b0);
    applyStimulus(32'h0000_0204, 32'h1122_3344, 4'h6, 1'b1, 2, 1'b0);
    applyStimulus(32'h0000_0208, 32'hA5A5_A5A5, 4'hF, 1'b1, 0, 1'b0);
    applyStimulus(32'h0000_0204, 32'h0, 4'h0, 1'b0, 0, 1'b0);

    $display("[TB] back-to-back reads with stb held");
    for (int i = 0; i < 4; i++)
      applyStimulus(32'(i * 4), $urandom, 4'hF, 1'b0, 0, i != 3);

    $display("[TB] zero-select write");
    applyStimulus(32'h0000_0030, $urandom, 4'h0, 1'b1, 0, 1'b0);

    $display("[TB] stray ready while idle");
    ready = 1'b1; rdata = $urandom;
    cycle();
    ready = 1'b0;
    checkOutput("stray valid", {31'd0, valid}, 32'd0);
    checkOutput("stray ack", {31'd0, wbAck}, 32'd0);
    checkOutput("stray wbdata", wbDataO, expWbData);

    $display("[TB] master abort");
    wbAddr = 32'h48; wbWe = 1'b0; wbSel = 4'hF; wbCyc = 1'b1; wbStb = 1'b1;
    expWbData = refMem[2];
    cycle();
    checkOutput("abort valid", {31'd0, valid}, 32'd1);
    wbCyc = 1'b0; wbStb = 1'b0;
    repeat (2) begin
      cycle();
      checkOutput("abort hold valid", {31'd0, valid}, 32'd1);
      checkOutput("abort hold address", address, 32'h48);
    end
    rdata = slvMem[address[5:2]]; ready = 1'b1;
    cycle();
    ready = 1'b0;
    checkOutput("abort no ack", {31'd0, wbAck}, 32'd0);
    checkOutput("abort valid low", {31'd0, valid}, 32'd0);
    checkOutput("abort wbdata", wbDataO, expWbData);
    cycle();
    checkOutput("abort still no ack", {31'd0, wbAck}, 32'd0);

    $display("[TB] reset mid-transaction");
    wbAddr = 32'h1C; wbWe = 1'b0; wbSel = 4'hF; wbCyc = 1'b1; wbStb = 1'b1;
    cycle();
    checkOutput("rst req valid", {31'd0, valid}, 32'd1);
    arst = 1'b1; wbCyc = 1'b0; wbStb = 1'b0;
    cycle();
    checkOutput("rst valid", {31'd0, valid}, 32'd0);
    checkOutput("rst ack", {31'd0, wbAck}, 32'd0);
    checkOutput("rst address", address, 32'd0);
    checkOutput("rst wdata", wdata, 32'd0);
    checkOutput("rst wbdata", wbDataO, 32'd0);
    arst = 1'b0;
    expWbData = '0;
    cycle();
    checkOutput("rst no late ack", {31'd0, wbAck}, 32'd0);
    applyStimulus(32'h1C, $urandom, 4'hF, 1'b0, 1, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      rAddr = $urandom;
      rAddr[1:0] = 2'b00;
      applyStimulus(rAddr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    wbCyc = 1'b0; wbStb = 1'b0;
    cycle();

`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    timeoutCfg = 16'd8;
    wbAddr = 32'h50; wbWe = 1'b0; wbSel = 4'hF; wbCyc = 1'b1; wbStb = 1'b1;
    validCycles = 0;
    cycle();
    for (int k = 0; k < 30 && valid === 1'b1; k++) begin
      validCycles++;
      checkOutput("tmo no early err", {31'd0, wbErr}, 32'd0);
      cycle();
    end
    checkOutput("tmo valid cycles", 32'(validCycles), 32'd8);
    checkOutput("tmo err pulse", {31'd0, wbErr}, 32'd1);
    checkOutput("tmo no ack", {31'd0, wbAck}, 32'd0);
    checkOutput("tmo wbdata held", wbDataO, expWbData);
    wbCyc = 1'b0; wbStb = 1'b0;
    cycle();
    checkOutput("tmo err one cycle", {31'd0, wbErr}, 32'd0);
    ready = 1'b1; rdata = $urandom;
    cycle();
    ready = 1'b0;
    checkOutput("tmo late ready ack", {31'd0, wbAck}, 32'd0);
    checkOutput("tmo late ready valid", {31'd0, valid}, 32'd0);
    checkOutput("tmo late ready wbdata", wbDataO, expWbData);
    timeoutCfg = '0;
`else
    validCycles = 0;
    checkOutput("err tied low", {31'd0, wbErr}, 32'(validCycles));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
